// File: rtl/fc_relu_buffer.sv
// Collects M shifted (and optionally rectified) FC outputs, then drains them in order.
// Optional ReLU on capture is enabled by defining FC_RELU_EN.
module fc_relu_buffer #(
  parameter int M  = 6,
  parameter int T  = 20,
  parameter int SH = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data,
  output logic                output_last
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state_q;
  logic [CW-1:0]       wr_cnt_q;
  logic [CW-1:0]       rd_cnt_q;
  logic signed [T-1:0] buf_q [M];

  logic signed [T-1:0] shifted;
  logic signed [T-1:0] proc_d;
  logic                in_fire;
  logic                out_fire;
  logic                wr_last;
  logic                rd_last;

  assign shifted = input_data >>> SH;

  always_comb begin
    proc_d = shifted;
`ifdef FC_RELU_EN
    if (shifted[T-1]) proc_d = '0;
`endif
  end

  // Handshake outputs are forced low during reset regardless of the stored state.
  assign input_ready  = !reset && (state_q == FILL);
  assign output_valid = !reset && (state_q == DRAIN);
  assign wr_last      = (wr_cnt_q == CW'(M - 1));
  assign rd_last      = (rd_cnt_q == CW'(M - 1));
  assign output_last  = output_valid && rd_last;
  assign output_data  = buf_q[rd_cnt_q];
  assign in_fire      = input_valid && input_ready;
  assign out_fire     = output_valid && output_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            if (wr_last) begin
              wr_cnt_q <= '0;
              state_q  <= DRAIN;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_last) begin
              rd_cnt_q <= '0;
              state_q  <= FILL;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Buffer entries carry no reset; each slot loads only when its index is written.
  for (genvar gi = 0; gi < M; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (in_fire && (wr_cnt_q == CW'(gi))) buf_q[gi] <= proc_d;
    end
  end

endmodule

// File: tb/tb_fc_relu_buffer.sv
// Directed bench for fc_relu_buffer (M=6, T=20, SH=1); expectations follow FC_RELU_EN.
module tb_fc_relu_buffer;
  localparam int M  = 6;
  localparam int T  = 20;
  localparam int SH = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic signed [T-1:0] output_data;
  logic                output_last;

  int checks = 0;
  int errors = 0;
  int tog    = 0;

  // Input vectors and hand-computed results of (x >>> 1), with and without ReLU.
  int va[6] = '{-5, 7, -1, 4, 0, -20};
  int vb[6] = '{326, -284, 40, -41, 1000, -1};
  int vc[6] = '{2, -3, 6, -7, 100, -100};
  int vd[6] = '{10, 20, -30, 40, -50, 60};
  int ve[6] = '{1, -2, 3, -4, 5, -6};
`ifdef FC_RELU_EN
  int ea[6] = '{0, 3, 0, 2, 0, 0};
  int eb[6] = '{163, 0, 20, 0, 500, 0};
  int ec[6] = '{1, 0, 3, 0, 50, 0};
  int ed[6] = '{5, 10, 0, 20, 0, 30};
  int ee[6] = '{0, 0, 1, 0, 2, 0};
`else
  int ea[6] = '{-3, 3, -1, 2, 0, -10};
  int eb[6] = '{163, -142, 20, -21, 500, -1};
  int ec[6] = '{1, -2, 3, -4, 50, -50};
  int ed[6] = '{5, 10, -15, 20, -25, 30};
  int ee[6] = '{0, -1, 1, -2, 2, -3};
`endif

  fc_relu_buffer #(.M(M), .T(T), .SH(SH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one element, optionally after a random idle gap, and wait for acceptance.
  task automatic push(input int d, input bit gaps);
    int n;
    bit acc;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    input_valid = 1'b1;
    input_data  = T'(d);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      if (input_ready) acc = 1'b1;
      tick();
      n++;
    end
    input_valid = 1'b0;
    check("push_timeout", int'(acc), 1);
    $display("push in=%0d accepted=%0d", d, acc);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic pop(input int exp_d, input bit exp_l, input int mode, input string tag);
    int n;
    bit done;
    int hold_d;
    bit hold_l;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      case (mode)
        0:       output_ready = 1'b1;
        1:       output_ready = pat[tog % 4];
        default: output_ready = 1'($urandom_range(0, 1));
      endcase
      tog++;
      #1;
      if (output_valid && output_ready) begin
        check({tag, "_data"}, int'(output_data), exp_d);
        check({tag, "_last"}, int'(output_last), int'(exp_l));
        $display("pop %s out=%0d last=%0d", tag, output_data, output_last);
        tick();
        done = 1'b1;
      end else if (output_valid) begin
        hold_d = int'(output_data);
        hold_l = output_last;
        tick();
        check({tag, "_hold_data"}, int'(output_data), hold_d);
        check({tag, "_hold_last"}, int'(output_last), int'(hold_l));
        check({tag, "_hold_in_ready"}, int'(input_ready), 0);
      end else begin
        tick();
      end
      n++;
    end
    output_ready = 1'b0;
    check({tag, "_timeout"}, int'(done), 1);
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b1;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", int'(input_ready), 0);
    check("rst_out_valid", int'(output_valid), 0);
    check("rst_out_last", int'(output_last), 0);
    input_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(input_ready), 1);
    tick();

    // Vector A: back-to-back in and out, latency checks on both edges.
    for (int i = 0; i < M; i++) push(va[i], 1'b0);
    check("a_out_valid_rise", int'(output_valid), 1);
    check("a_in_ready_drop", int'(input_ready), 0);
    for (int i = 0; i < M; i++) pop(ea[i], i == M - 1, 0, $sformatf("a%0d", i));
    check("a_in_ready_rise", int'(input_ready), 1);
    check("a_out_valid_drop", int'(output_valid), 0);
    check("a_last_drop", int'(output_last), 0);

    // Vector B: output backpressure with a 1,0,0,1 ready pattern.
    for (int i = 0; i < M; i++) push(vb[i], 1'b0);
    tog = 0;
    for (int i = 0; i < M; i++) begin
      pop(eb[i], i == M - 1, 1, $sformatf("b%0d", i));
      if (i < M - 1) check("b_in_ready_low", int'(input_ready), 0);
    end
    check("b_in_ready_rise", int'(input_ready), 1);

    // Abort a partial fill with reset; the next vector must carry no residue.
    for (int i = 0; i < 3; i++) push(999, 1'b0);
    reset = 1'b1;
    input_valid = 1'b1;
    #1;
    check("midfill_rst_in_ready", int'(input_ready), 0);
    tick();
    check("midfill_rst_in_ready2", int'(input_ready), 0);
    input_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midfill_post_rst_ready", int'(input_ready), 1);
    for (int i = 0; i < M; i++) push(vc[i], 1'b0);
    for (int i = 0; i < M; i++) pop(ec[i], i == M - 1, 0, $sformatf("c%0d", i));

    // Two vectors with random input and output gaps.
    for (int i = 0; i < M; i++) push(vd[i], 1'b1);
    for (int i = 0; i < M; i++) pop(ed[i], i == M - 1, 2, $sformatf("d%0d", i));
    for (int i = 0; i < M; i++) push(ve[i], 1'b1);
    for (int i = 0; i < M; i++) pop(ee[i], i == M - 1, 2, $sformatf("e%0d", i));
    check("end_in_ready", int'(input_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_relu_buffer.md
FC_RELU_BUFFER -- requirements
Module: fc_relu_buffer

Interface
REQ-001 Parameter M, default 6: number of elements per vector produced by the upstream FC layer.
REQ-002 Parameter T, default 20: signed data width in bits.
REQ-003 Parameter SH, default 0: arithmetic right-shift amount applied to each element on capture; legal range 0 to T-1.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 input_valid  input  1: upstream FC output element is valid.
REQ-007 input_ready  output  1: block accepts an element this cycle.
REQ-008 input_data  input  T signed: upstream FC output element.
REQ-009 output_valid  output  1: output_data holds a valid element.
REQ-010 output_ready  input  1: downstream layer accepts the element.
REQ-011 output_data  output  T signed: processed element to the next layer.
REQ-012 output_last  output  1: high with output_valid on the final element (index M-1) of a vector.

Function
REQ-013 Two states SHALL be used: FILL and DRAIN; reset enters FILL.
REQ-014 In FILL: input_ready=1 and output_valid=0; a transfer occurs when input_valid && input_ready are high at a rising edge.
REQ-015 Each accepted element SHALL be processed and stored at index wr_cnt; wr_cnt then increments.
REQ-016 Processing SHALL be: arithmetic right shift by SH (sign-preserving, floor rounding), then the optional ReLU (REQ-028); the result is T bits.
REQ-017 When the element at wr_cnt=M-1 is accepted, wr_cnt SHALL return to 0 and the state SHALL become DRAIN on the next cycle.
REQ-018 In DRAIN: input_ready=0 and output_valid=1; output_data is the stored element at rd_cnt, driven combinationally from buffer flops.
REQ-019 output_last SHALL equal (rd_cnt==M-1) while in DRAIN, and 0 otherwise.
REQ-020 A downstream transfer occurs when output_valid && output_ready are high at a rising edge; rd_cnt then increments.
REQ-021 When the element at rd_cnt=M-1 transfers, rd_cnt SHALL return to 0 and the state SHALL become FILL on the next cycle.
REQ-022 Latency: output_valid SHALL rise in the cycle immediately after the M-th input transfer; input_ready SHALL rise in the cycle immediately after the last output transfer.
REQ-023 While output_ready=0 in DRAIN, output_data, output_last and rd_cnt SHALL hold stable.
REQ-024 input_valid gaps in FILL and output_ready gaps in DRAIN SHALL only stall; no element is lost or duplicated.
REQ-025 M=1 SHALL work: the block alternates one input transfer and one output transfer.

Reset
REQ-026 While reset=1, input_ready=0, output_valid=0 and output_last=0, regardless of state; on the first cycle after release, input_ready=1.
REQ-027 Reset SHALL clear the state to FILL and wr_cnt/rd_cnt to 0 at any point, including mid-fill or mid-drain; the partial vector is discarded; buffer contents need no reset.

Configuration
REQ-028 Macro FC_RELU_EN defined: negative post-shift values SHALL be stored as 0; FC_RELU_EN undefined: post-shift values are stored unchanged (signed pass-through).

Verification
REQ-029 FC_RELU_EN, SH=0, M=6: inputs 163,-103,-329,75,364,-10 back-to-back, output_ready=1 -> outputs 163,0,0,75,364,0 on consecutive cycles, output_last only on the 6th, output_valid rising the cycle after the 6th input.
REQ-030 FC_RELU_EN undefined, SH=1: inputs -5,7,-1,4,0,-20 -> outputs -3,3,-1,2,0,-10.
REQ-031 FC_RELU_EN, SH=2: input 163 -> 40; input -142 -> 0.
REQ-032 Backpressure: output_ready toggled 1,0,0,1,... during DRAIN -> each element is held until accepted, exactly 6 transfers occur in order, and input_ready stays 0 until the cycle after the last transfer.
REQ-033 Reset asserted after 3 of 6 inputs are accepted -> input_ready=0 during reset; after release, a fresh 6-element vector is output exactly, with no residue from the aborted fill.
REQ-034 Two vectors streamed with random input_valid gaps -> 12 outputs in input order, output_last on outputs 6 and 12.
